// File: rtl/bus_master_requester_pkg.sv
// Shared bus definitions for the master-side arbitration requester:
// state encoding, error codes and the slave-index width.
package bus_master_requester_pkg;

    localparam int SLAVE_W = 2;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_BUS   = 3'd1;
    localparam logic [2:0] ST_ADDR0      = 3'd2;
    localparam logic [2:0] ST_ADDR1      = 3'd3;
    localparam logic [2:0] ST_WAIT_GRANT = 3'd4;
    localparam logic [2:0] ST_XFER       = 3'd5;
    localparam logic [2:0] ST_RELEASE    = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_WAIT_BUS   = ST_WAIT_BUS,
        S_ADDR0      = ST_ADDR0,
        S_ADDR1      = ST_ADDR1,
        S_WAIT_GRANT = ST_WAIT_GRANT,
        S_XFER       = ST_XFER,
        S_RELEASE    = ST_RELEASE
    } state_t;

    localparam logic [1:0] ERR_NONE       = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT    = 2'd1;
    localparam logic [1:0] ERR_GRANT_LOST = 2'd2;

endpackage

// File: rtl/bus_master_requester.sv
// Master-side bus requester: waits for an idle arbiter, requests the bus while
// shifting the slave index out LSB first, then owns the bus for a counted burst.
module bus_master_requester
    import bus_master_requester_pkg::*;
#(
    parameter int LEN_W         = 4,
    parameter int GRANT_TIMEOUT = 16,
    parameter int TO_W          = $clog2(GRANT_TIMEOUT + 1)
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               cmd_valid,
    input  logic [SLAVE_W-1:0] cmd_slave,
    input  logic [LEN_W-1:0]   cmd_len,
    output logic               cmd_ready,
    input  logic               arbiter_busy,
    input  logic               m_grant,
    output logic               m_request,
    output logic               m_slave_sel,
    input  logic               beat_en,
    output logic               xfer_active,
    output logic [LEN_W-1:0]   beats_left,
    output logic               done,
    output logic               err_valid,
    output logic [1:0]         err_code
);

    // The timeout and beat counters never run together, so they share a register.
    localparam int CNT_W = (LEN_W > TO_W) ? LEN_W : TO_W;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(GRANT_TIMEOUT - 1);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [SLAVE_W-1:0] slave_reg, slave_next;
    logic [LEN_W-1:0]   len_reg, len_next;

    logic               cmd_ready_next;
    logic               m_request_next;
    logic               m_slave_sel_next;
    logic               xfer_active_next;
    logic [LEN_W-1:0]   beats_left_next;
    logic               done_next;
    logic               err_valid_next;
    logic [1:0]         err_code_next;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        slave_next     = slave_reg;
        len_next       = len_reg;
        done_next      = 1'b0;
        err_valid_next = 1'b0;
        err_code_next  = ERR_NONE;

        case (state_reg)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    slave_next = cmd_slave;
                    len_next   = cmd_len;
                    state_next = S_WAIT_BUS;
                end
            end
            S_WAIT_BUS: begin
                if (!arbiter_busy) begin
                    state_next = S_ADDR0;
                end
            end
            S_ADDR0: state_next = S_ADDR1;
            S_ADDR1: begin
                cnt_next   = '0;
                state_next = S_WAIT_GRANT;
            end
            S_WAIT_GRANT: begin
                if (m_grant) begin
                    cnt_next   = CNT_W'(len_reg);
                    state_next = S_XFER;
                end else if (cnt_reg == TO_LAST) begin
                    err_valid_next = 1'b1;
                    err_code_next  = ERR_TIMEOUT;
                    state_next     = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_XFER: begin
                // Losing the grant wins over a beat arriving in the same cycle.
                if (!m_grant) begin
                    err_valid_next = 1'b1;
                    err_code_next  = ERR_GRANT_LOST;
                    state_next     = S_RELEASE;
                end else if (beat_en) begin
                    if (cnt_reg == '0) begin
                        done_next  = 1'b1;
                        state_next = S_RELEASE;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
            end
            S_RELEASE: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase

        // Outputs are decoded from the upcoming state so the registered values
        // line up with the state they describe.
        cmd_ready_next   = (state_next == S_IDLE);
        m_request_next   = (state_next == S_ADDR0) || (state_next == S_ADDR1) ||
                           (state_next == S_WAIT_GRANT) || (state_next == S_XFER);
        xfer_active_next = (state_next == S_XFER);
        beats_left_next  = xfer_active_next ? cnt_next[LEN_W-1:0] : '0;
        m_slave_sel_next = 1'b0;
        if (state_next == S_ADDR0) begin
            m_slave_sel_next = slave_next[0];
        end else if (state_next == S_ADDR1) begin
            m_slave_sel_next = slave_next[1];
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            slave_reg   <= '0;
            len_reg     <= '0;
            cmd_ready   <= 1'b1;
            m_request   <= 1'b0;
            m_slave_sel <= 1'b0;
            xfer_active <= 1'b0;
            beats_left  <= '0;
            done        <= 1'b0;
            err_valid   <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            slave_reg   <= slave_next;
            len_reg     <= len_next;
            cmd_ready   <= cmd_ready_next;
            m_request   <= m_request_next;
            m_slave_sel <= m_slave_sel_next;
            xfer_active <= xfer_active_next;
            beats_left  <= beats_left_next;
            done        <= done_next;
            err_valid   <= err_valid_next;
            err_code    <= err_code_next;
        end
    end

endmodule

// File: tb/tb_bus_master_requester.sv
// Scoreboard bench for bus_master_requester: stimulus pushes expected transaction
// outcomes, a negedge monitor pops and compares them on every done/err pulse.
module tb_bus_master_requester;

    localparam int LEN_W = 4;
    localparam int GT    = 16;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_slave = 2'd0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             arbiter_busy = 1'b0;
    logic             m_grant = 1'b0;
    logic             beat_en = 1'b0;
    logic             cmd_ready;
    logic             m_request;
    logic             m_slave_sel;
    logic             xfer_active;
    logic [LEN_W-1:0] beats_left;
    logic             done;
    logic             err_valid;
    logic [1:0]       err_code;

    bus_master_requester #(
        .LEN_W         (LEN_W),
        .GRANT_TIMEOUT (GT)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .cmd_valid    (cmd_valid),
        .cmd_slave    (cmd_slave),
        .cmd_len      (cmd_len),
        .cmd_ready    (cmd_ready),
        .arbiter_busy (arbiter_busy),
        .m_grant      (m_grant),
        .m_request    (m_request),
        .m_slave_sel  (m_slave_sel),
        .beat_en      (beat_en),
        .xfer_active  (xfer_active),
        .beats_left   (beats_left),
        .done         (done),
        .err_valid    (err_valid),
        .err_code     (err_code)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        bit       is_err;
        int       code;
        int       slave;
        int       req;
        int       beats;
        int       len;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int checks = 0;
    int errors = 0;
    int ev_count = 0;
    int last_low_run = 0;

    // Monitor state
    int         req_cnt = 0;
    int         beats = 0;
    int         low_run = 0;
    int         exp_bl = 0;
    bit         have_exp = 0;
    bit         prev_req = 0;
    bit         prev_xfer = 0;
    logic [1:0] cap_slave = 2'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input bit is_err, input int code, input int slave,
                                input int req, input int bts, input int len);
        exp_t r;
        r.is_err = is_err;
        r.code   = code;
        r.slave  = slave;
        r.req    = req;
        r.beats  = bts;
        r.len    = len;
        return r;
    endfunction

    always @(negedge sys_clk) begin
        if (sys_rst) begin
            req_cnt   = 0;
            beats     = 0;
            low_run   = 0;
            prev_req  = 0;
            prev_xfer = 0;
            cap_slave = 2'd0;
        end else begin
            if (m_request) begin
                if (!prev_req) begin
                    last_low_run = low_run;
                    req_cnt      = 0;
                    beats        = 0;
                    cap_slave    = 2'd0;
                end
                if (req_cnt == 0) cap_slave[0] = m_slave_sel;
                else if (req_cnt == 1) cap_slave[1] = m_slave_sel;
                req_cnt++;
                low_run = 0;
            end else begin
                low_run++;
            end
            if (xfer_active) begin
                if (!prev_xfer) begin
                    have_exp = (exp_q.size() > 0);
                    if (have_exp) exp_bl = exp_q[0].len;
                end
                if (have_exp) check("beats_left", 32'(beats_left), 32'(exp_bl));
                if (beat_en && m_grant) begin
                    beats++;
                    exp_bl--;
                end
            end
            if (done || err_valid) begin
                ev_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got done=%0b err_valid=%0b, expected no pulse",
                             done, err_valid);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_kind", 32'({done, err_valid}), 32'(e.is_err ? 2'b01 : 2'b10));
                    if (e.is_err) check("err_code", 32'(err_code), 32'(e.code));
                    check("slave_bits", 32'(cap_slave), 32'(e.slave));
                    check("req_cycles", 32'(req_cnt), 32'(e.req));
                    check("beat_count", 32'(beats), 32'(e.beats));
                    $display("txn: slave=%0d req_cycles=%0d beats=%0d done=%0b err=%0b code=%0d",
                             cap_slave, req_cnt, beats, done, err_valid, err_code);
                end
            end
            prev_req  = m_request;
            prev_xfer = xfer_active;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] slave, input logic [LEN_W-1:0] len);
        cmd_slave = slave;
        cmd_len   = len;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_events(input int target, input string name);
        int n = 0;
        while (ev_count < target && n < 100) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        check(name, 32'(ev_count >= target), 32'(1));
    endtask

    // which: 0 = wait for m_request, 1 = wait for xfer_active
    task automatic wait_sig(input int which, input string name);
        int n = 0;
        logic s;
        s = 1'b0;
        while (n < 50) begin
            @(negedge sys_clk);
            #1;
            n++;
            s = (which == 0) ? m_request : xfer_active;
            if (s) break;
        end
        check(name, 32'(s), 32'(1));
    endtask

    task automatic check_idle(input string name);
        check({name, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
        check({name, "_m_request"}, 32'(m_request), 32'(0));
        check({name, "_slave_sel"}, 32'(m_slave_sel), 32'(0));
        check({name, "_xfer_active"}, 32'(xfer_active), 32'(0));
        check({name, "_beats_left"}, 32'(beats_left), 32'(0));
        check({name, "_done"}, 32'(done), 32'(0));
        check({name, "_err_valid"}, 32'(err_valid), 32'(0));
        check({name, "_err_code"}, 32'(err_code), 32'(0));
    endtask

    initial begin
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        @(negedge sys_clk);
        #1;
        check_idle("reset");

        // Normal 4-beat burst to slave 2
        m_grant = 1'b1;
        beat_en = 1'b1;
        exp_q.push_back(mk(0, 0, 2, 7, 4, 3));
        tick();
        issue(2'b10, 4'd3);
        wait_events(1, "burst_event");

        // Arbiter busy for 5 cycles after accept
        tick();
        tick();
        arbiter_busy = 1'b1;
        exp_q.push_back(mk(0, 0, 1, 4, 1, 0));
        issue(2'b01, 4'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            check("busy_req_low", 32'(m_request), 32'(0));
            tick();
        end
        arbiter_busy = 1'b0;
        @(negedge sys_clk);
        check("busy_fall_req_low", 32'(m_request), 32'(0));
        tick();
        @(negedge sys_clk);
        check("busy_after_req_high", 32'(m_request), 32'(1));
        wait_events(2, "busy_event");

        // Grant never arrives
        tick();
        tick();
        m_grant = 1'b0;
        exp_q.push_back(mk(1, 1, 3, 2 + GT, 0, 2));
        issue(2'b11, 4'd2);
        wait_events(3, "timeout_event");
        check("timeout_cmd_ready", 32'(cmd_ready), 32'(1));
        check("timeout_req_low", 32'(m_request), 32'(0));
        m_grant = 1'b1;

        // Grant lost after 2 of 4 beats, beat_en still high
        tick();
        tick();
        exp_q.push_back(mk(1, 2, 0, 6, 2, 3));
        issue(2'b00, 4'd3);
        wait_sig(1, "lost_xfer_start");
        tick();
        tick();
        m_grant = 1'b0;
        wait_events(4, "lost_event");
        check("lost_req_low", 32'(m_request), 32'(0));
        check("lost_no_done", 32'(done), 32'(0));
        tick();
        m_grant = 1'b1;

        // Reset during ADDR1
        tick();
        issue(2'b10, 4'd1);
        wait_sig(0, "rst_addr_req");
        tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        @(negedge sys_clk);
        #1;
        check_idle("rst_addr1");
        repeat (5) tick();

        // Reset during XFER
        issue(2'b01, 4'd2);
        wait_sig(1, "rst_xfer_start");
        tick();
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        @(negedge sys_clk);
        #1;
        check_idle("rst_xfer");
        repeat (5) tick();

        // Back-to-back single-beat bursts
        exp_q.push_back(mk(0, 0, 1, 4, 1, 0));
        exp_q.push_back(mk(0, 0, 2, 4, 1, 0));
        cmd_slave = 2'b01;
        cmd_len   = 4'd0;
        cmd_valid = 1'b1;
        tick();
        cmd_slave = 2'b10;
        wait_events(ev_count + 1, "b2b_first_event");
        tick();
        tick();
        cmd_valid = 1'b0;
        wait_events(ev_count + 1, "b2b_second_event");
        check("b2b_gap", 32'(last_low_run), 32'(3));

        repeat (4) tick();
        check("queue_empty", 32'(exp_q.size()), 32'(0));
        check("event_total", 32'(ev_count), 32'(6));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_master_requester.md
# bus_master_requester

Master-side initiator for the system bus arbitration protocol. It accepts a local transaction command and checks that the arbiter is idle. It then raises the master's request line, shifts the 2-bit target slave select out serially (LSB first) on the slave-select line, and waits for the grant. Once granted, it holds the bus for a counted burst and then releases it. One instance sits in each master (m1, m2), between the master's local control logic and the arbiter.

## Interface
Parameters:
- LEN_W, 4: width of the burst-length field; a burst is cmd_len+1 beats (1..2^LEN_W).
- GRANT_TIMEOUT, 16: maximum cycles in WAIT_GRANT before abort; must be ≥ 2.
- TO_W, $clog2(GRANT_TIMEOUT+1): timeout counter width.

Ports:
- sys_clk  in  1  single clock; all logic is rising-edge.
- sys_rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  local command present.
- cmd_slave  in  2  target slave index.
- cmd_len  in  LEN_W  burst length minus one.
- cmd_ready  out  1  high only in IDLE; the command is accepted on a cycle where cmd_valid && cmd_ready.
- arbiter_busy  in  1  arbiter is currently serving an address phase.
- m_grant  in  1  grant from the arbiter (level).
- m_request  out  1  request to the arbiter.
- m_slave_sel  out  1  serial slave select to the arbiter.
- beat_en  in  1  local datapath consumed one beat this cycle (counted only in XFER).
- xfer_active  out  1  bus owned; local datapath may transfer.
- beats_left  out  LEN_W  remaining beats minus one while in XFER.
- done  out  1  one-cycle pulse; burst completed normally.
- err_valid  out  1  one-cycle pulse; transaction aborted.
- err_code  out  2  valid with err_valid: 1 = grant timeout, 2 = grant lost in XFER.

## Operation
All outputs are registered. Reset value of every output is 0, except cmd_ready, which is 1 (IDLE).

States: IDLE, WAIT_BUS, ADDR0, ADDR1, WAIT_GRANT, XFER, RELEASE.
- IDLE: cmd_ready=1. On accept, latch cmd_slave and cmd_len, then go to WAIT_BUS.
- WAIT_BUS: m_request=0.
  - If arbiter_busy=0, go to ADDR0.
  - Otherwise stay in WAIT_BUS indefinitely; there is no timeout here.
- ADDR0: m_request=1, m_slave_sel=slave[0]. Go to ADDR1 unconditionally.
- ADDR1: m_request=1, m_slave_sel=slave[1]. Go to WAIT_GRANT, clearing the timeout counter.
- WAIT_GRANT: m_request=1, m_slave_sel=0. Evaluate in this order:
  - If m_grant=1, go to XFER and load the beat counter with the latched length.
  - Else if the counter equals GRANT_TIMEOUT-1, pulse err_valid with err_code=1 and go to IDLE (m_request=0 in the IDLE cycle).
  - Else increment the counter.
- XFER: m_request=1, xfer_active=1, beats_left=counter.
  - If m_grant=0, pulse err_valid with err_code=2 and go to RELEASE. This check has priority over beat_en.
  - Else if beat_en=1 and counter=0, go to RELEASE with done to pulse.
  - Else if beat_en=1, decrement the counter.
- RELEASE: m_request=0, xfer_active=0. done (normal completion only) is high for this single cycle. Go to IDLE.
- m_grant is ignored outside WAIT_GRANT and XFER.
- cmd_valid is ignored outside IDLE.

## Timing
- Accept at edge N puts the block in WAIT_BUS during cycle N+1. If arbiter_busy=0 in that cycle, the address phase follows:
  - m_request rises and bit0 appears in cycle N+2.
  - bit1 appears in cycle N+3.
  - The arbiter samples bit0 at the edge ending the first request cycle and bit1 one edge later.
- Minimum latency from accept to xfer_active is 4 cycles (grant seen in the first WAIT_GRANT cycle).
- Timeout: m_request stays high for exactly 2 + GRANT_TIMEOUT cycles, then drops.
- A burst of L+1 beats needs L+1 beat_en cycles in XFER. The pulse on done follows the last beat by one cycle.
- Back-to-back: the earliest next accept is the IDLE cycle after RELEASE, so m_request is low for at least 3 cycles between transactions.
- Sync reset mid-operation: at the next edge all state returns to IDLE, m_request=0, and no done or err pulse is generated.

## Structure
- A shared bus package holds:
  - the state encoding (3-bit localparams),
  - the err_code constants ERR_NONE=0, ERR_TIMEOUT=1, ERR_GRANT_LOST=2,
  - the slave-index width (2).
- No sub-module is needed. The FSM, the timeout counter and the beat counter live in one module. The timeout and beat counters may share one register, since their states are disjoint.

## Test plan
- cmd_slave=2'b10, cmd_len=3, arbiter_busy=0, m_grant=1 from the first WAIT_GRANT cycle -> m_slave_sel is 0 then 1 on consecutive request cycles; xfer_active lasts 4 beat_en cycles; beats_left goes 3,2,1,0; done pulses once.
- arbiter_busy=1 for 5 cycles after accept -> m_request stays 0 through those cycles and rises the cycle after busy falls.
- m_grant never asserted, GRANT_TIMEOUT=16 -> m_request high for 18 cycles; err_valid pulses with err_code=1; cmd_ready returns next cycle.
- m_grant drops after 2 of 4 beats -> err_code=2 pulse, no done, m_request low the next cycle.
- sys_rst asserted in ADDR1 and in XFER -> all outputs at reset values after one edge; no pulses.
- Two commands back-to-back (cmd_len=0) -> two single-beat bursts; m_request low for 3 cycles between them.
